// File: rtl/watch_pkg.sv
// Watch-wide constants: clock-derived counts, key timing defaults and the mode encoding.
package watch_pkg;

  localparam int SECOND_CNT    = 52428800;
  localparam int DEBOUNCE_CNT  = 1048576;
  localparam int REPEAT_DELAY  = 26214400;
  localparam int REPEAT_PERIOD = 10485760;
  localparam int COUNTER_WIDTH = 26;

  typedef enum logic {
    MODE_SET   = 1'b0,
    MODE_TIMER = 1'b1
  } mode_e;

endpackage

// File: rtl/key_debounce.sv
// One push-button: two-flop synchroniser, debounce counter and a registered press strobe.
module key_debounce
  import watch_pkg::*;
#(
  parameter int debounce_cnt  = DEBOUNCE_CNT,
  parameter int counter_width = COUNTER_WIDTH
) (
  input  logic clock,
  input  logic reset,
  input  logic i_key,
  output logic o_level,
  output logic o_press
);

  localparam logic [counter_width-1:0] LP_LAST = counter_width'(debounce_cnt - 1);

  logic                     r_s1, r_s2, r_stable, r_press;
  logic [counter_width-1:0] r_cnt;
  logic                     w_hit;

  // The edge on which the counter would reach debounce_cnt accepts the new level.
  assign w_hit = (r_s2 != r_stable) && (r_cnt == LP_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s1     <= 1'b1;
      r_s2     <= 1'b1;
      r_stable <= 1'b1;
      r_press  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_s1    <= i_key;
      r_s2    <= r_s1;
      r_press <= w_hit & r_stable;
      if (r_s2 == r_stable) begin
        r_cnt <= '0;
      end else if (w_hit) begin
        r_stable <= r_s2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_stable;
  assign o_press = r_press;

endmodule

// File: rtl/key_ctrl.sv
// Watch key front end: mode toggle and gated minute/hour set pulses.
// KEY_AUTO_REPEAT_EN adds auto-repeat on held minute/hour keys in Set mode.
module key_ctrl
  import watch_pkg::*;
#(
  parameter int debounce_cnt  = DEBOUNCE_CNT,
  parameter int repeat_delay  = REPEAT_DELAY,
  parameter int repeat_period = REPEAT_PERIOD,
  parameter int counter_width = COUNTER_WIDTH
) (
  input  logic clock,
  input  logic reset,
  input  logic key_mode,
  input  logic key_minute,
  input  logic key_hour,
  output logic mode,
  output logic minute_set,
  output logic hour_set
);

  logic       r_mode;
  logic [1:0] r_set;
  logic       w_mode_lvl, w_mode_press;
  logic [1:0] w_raw, w_lvl, w_press, w_rpt;
  logic       w_unused;

  // Index 0 = minute, 1 = hour.
  assign w_raw = {key_hour, key_minute};

  key_debounce #(.debounce_cnt(debounce_cnt), .counter_width(counter_width)) u_deb_mode (
    .clock   (clock),
    .reset   (reset),
    .i_key   (key_mode),
    .o_level (w_mode_lvl),
    .o_press (w_mode_press)
  );

  for (genvar k = 0; k < 2; k++) begin : g_key
    key_debounce #(.debounce_cnt(debounce_cnt), .counter_width(counter_width)) u_deb (
      .clock   (clock),
      .reset   (reset),
      .i_key   (w_raw[k]),
      .o_level (w_lvl[k]),
      .o_press (w_press[k])
    );

`ifdef KEY_AUTO_REPEAT_EN
    localparam logic [counter_width-1:0] LP_DELAY_LAST  = counter_width'(repeat_delay - 1);
    localparam logic [counter_width-1:0] LP_PERIOD_LAST = counter_width'(repeat_period - 1);

    logic                     r_act, r_first;
    logic [counter_width-1:0] r_cnt;

    assign w_rpt[k] = r_act && !w_lvl[k] && (r_mode == MODE_SET) &&
                      (r_cnt == (r_first ? LP_DELAY_LAST : LP_PERIOD_LAST));

    // Armed by the press pulse itself; dropped on release or on leaving Set mode.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_act   <= 1'b0;
        r_first <= 1'b0;
        r_cnt   <= '0;
      end else if (w_press[k] && (r_mode == MODE_SET)) begin
        r_act   <= 1'b1;
        r_first <= 1'b1;
        r_cnt   <= '0;
      end else if (!r_act || w_lvl[k] || (r_mode == MODE_TIMER)) begin
        r_act   <= 1'b0;
        r_first <= 1'b0;
        r_cnt   <= '0;
      end else if (w_rpt[k]) begin
        r_first <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
`else
    assign w_rpt[k] = 1'b0;
`endif
  end

`ifndef KEY_AUTO_REPEAT_EN
  logic w_unused_rpt;
  assign w_unused_rpt = ^{w_lvl, repeat_delay[0], repeat_period[0]};
`endif
  assign w_unused = w_mode_lvl;

  // Gating uses the mode held before this edge's toggle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mode <= MODE_TIMER;
      r_set  <= '0;
    end else begin
      r_set <= (w_press | w_rpt) & {2{r_mode == MODE_SET}};
      if (w_mode_press) r_mode <= ~r_mode;
    end
  end

  assign mode       = r_mode;
  assign minute_set = r_set[0];
  assign hour_set   = r_set[1];

endmodule

// File: tb/tb_key_ctrl.sv
// Self-checking bench for key_ctrl with a run-length behavioural model of the key path.
module tb_key_ctrl;

  localparam int D  = 8;
  localparam int RD = 20;
  localparam int RP = 5;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic key_mode = 1'b1, key_minute = 1'b1, key_hour = 1'b1;
  logic mode, minute_set, hour_set;

  int chk = 0;
  int err = 0;
  int cyc = 0;

  key_ctrl #(.debounce_cnt(D), .repeat_delay(RD), .repeat_period(RP), .counter_width(26)) dut (
    .clock      (clock),
    .reset      (reset),
    .key_mode   (key_mode),
    .key_minute (key_minute),
    .key_hour   (key_hour),
    .mode       (mode),
    .minute_set (minute_set),
    .hour_set   (hour_set)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- behavioural model ----------------
  bit m_mode, m_min, m_hour;
  bit hist0[3], hist1[3], stable[3], pend[3];
  int run[3];
  bit act[2];
  int last_e[2];
  int mcyc;

  task automatic model_init();
    m_mode = 1'b1; m_min = 1'b0; m_hour = 1'b0;
    for (int k = 0; k < 3; k++) begin
      hist0[k] = 1'b1; hist1[k] = 1'b1; stable[k] = 1'b1; pend[k] = 1'b0; run[k] = 0;
    end
    for (int k = 0; k < 2; k++) begin
      act[k] = 1'b0; last_e[k] = 0;
    end
  endtask

  initial begin
    bit raw[3];
    bit fire[2];
    bit seen;
    int age;
    mcyc = 0;
    model_init();
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        model_init();
      end else begin
        mcyc++;
        raw[0] = key_mode; raw[1] = key_minute; raw[2] = key_hour;
        for (int k = 0; k < 2; k++) begin
          fire[k] = 1'b0;
          if (pend[k+1] && !m_mode) begin
            fire[k] = 1'b1; act[k] = 1'b1; last_e[k] = mcyc;
          end
`ifdef KEY_AUTO_REPEAT_EN
          else if (act[k] && !stable[k+1] && !m_mode) begin
            age = mcyc - last_e[k];
            if (age == RD || (age > RD && (age - RD) % RP == 0)) fire[k] = 1'b1;
          end
`endif
          else act[k] = 1'b0;
        end
        m_min  = fire[0];
        m_hour = fire[1];
        if (pend[0]) m_mode = !m_mode;
        // A key level is accepted after D consecutive disagreeing samples, two edges late.
        for (int k = 0; k < 3; k++) begin
          seen = hist1[k];
          pend[k] = 1'b0;
          if (seen != stable[k]) begin
            run[k]++;
            if (run[k] == D) begin
              stable[k] = seen;
              run[k] = 0;
              pend[k] = !seen;
            end
          end else begin
            run[k] = 0;
          end
          hist1[k] = hist0[k];
          hist0[k] = raw[k];
        end
      end
    end
  end

  // ---------------- cycle-by-cycle compare + pulse monitor ----------------
  int q_min[$];
  int q_hr[$];
  int fall_cyc = -1;
  int rise_cyc = -1;
  logic prev_mode = 1'b1;

  initial begin
    forever begin
      @(negedge clock);
      chk++;
      if (mode !== m_mode || minute_set !== m_min || hour_set !== m_hour) begin
        err++;
        $display("FAIL model_cmp cyc=%0d got mode/min/hr=%b%b%b expected %b%b%b",
                 cyc, mode, minute_set, hour_set, m_mode, m_min, m_hour);
      end
      if (minute_set === 1'b1) q_min.push_back(cyc);
      if (hour_set === 1'b1) q_hr.push_back(cyc);
      if (prev_mode === 1'b1 && mode === 1'b0) fall_cyc = cyc;
      if (prev_mode === 1'b0 && mode === 1'b1) rise_cyc = cyc;
      prev_mode = mode;
    end
  end

  task automatic check(input string name, input int act_v, input int exp_v);
    chk++;
    if (act_v !== exp_v) begin
      err++;
      $display("FAIL %s: got %0d expected %0d", name, act_v, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic hold(input bit m, input bit mi, input bit h, input int n);
    key_mode = m; key_minute = mi; key_hour = h;
    step(n);
    key_mode = 1'b1; key_minute = 1'b1; key_hour = 1'b1;
    step(25);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int c0, nm, nh, base;
    int hold_left[3];
    bit lvl[3];
    int exp_off[7];

    step(3);
    check("reset_mode", int'(mode), 1);
    check("reset_pulses", int'(minute_set) + int'(hour_set), 0);
    reset = 1'b1;
    step(5);

    // Glitch shorter than the debounce window
    hold(1'b0, 1'b1, 1'b1, 7);
    check("glitch_mode", int'(mode), 1);
    check("glitch_pulses", q_min.size() + q_hr.size(), 0);

    // Mode press: falls 11 edges after the first low sample
    c0 = cyc;
    hold(1'b0, 1'b1, 1'b1, 30);
    check("mode_fall_edge", fall_cyc, c0 + 11);
    check("mode_set", int'(mode), 0);

    // Simultaneous minute + hour in Set mode
    nm = q_min.size(); nh = q_hr.size();
    hold(1'b1, 1'b0, 1'b0, 15);
    check("set_min_count", q_min.size() - nm, 1);
    check("set_hr_count", q_hr.size() - nh, 1);
    check("set_same_cycle", q_min[$], q_hr[$]);

    // Back to Timer, then presses must be suppressed
    hold(1'b0, 1'b1, 1'b1, 15);
    check("mode_timer", int'(mode), 1);
    nm = q_min.size(); nh = q_hr.size();
    hold(1'b1, 1'b0, 1'b0, 15);
    check("timer_suppress", (q_min.size() - nm) + (q_hr.size() - nh), 0);

    // Same-edge mode + minute from Set mode
    hold(1'b0, 1'b1, 1'b1, 15);
    check("mode_set2", int'(mode), 0);
    nm = q_min.size();
    hold(1'b0, 1'b0, 1'b1, 15);
    check("same_edge_count", q_min.size() - nm, 1);
    check("same_edge_cycle", rise_cyc, q_min[$]);
    check("same_edge_mode", int'(mode), 1);

    // Held minute key in Set mode
    hold(1'b0, 1'b1, 1'b1, 15);
    nm = q_min.size();
    c0 = cyc;
    hold(1'b1, 1'b0, 1'b1, 50);
`ifdef KEY_AUTO_REPEAT_EN
    exp_off = '{0, 20, 25, 30, 35, 40, 45};
    check("repeat_count", q_min.size() - nm, 7);
    if (q_min.size() - nm == 7) begin
      base = q_min[nm];
      check("repeat_first", base, c0 + 11);
      for (int i = 1; i < 7; i++) check("repeat_offset", q_min[nm+i] - base, exp_off[i]);
    end
`else
    check("single_pulse_count", q_min.size() - nm, 1);
    if (q_min.size() - nm == 1) check("single_pulse_cycle", q_min[nm], c0 + 11);
`endif

    // Random key activity with a reset in the middle
    for (int k = 0; k < 3; k++) begin
      lvl[k] = 1'b1; hold_left[k] = $urandom_range(1, 25);
    end
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) begin
        @(posedge clock); #3;
        reset = 1'b0;
        #1;
        check("midreset_mode", int'(mode), 1);
        check("midreset_pulses", int'(minute_set) + int'(hour_set), 0);
        step(3);
        reset = 1'b1;
      end
      for (int k = 0; k < 3; k++) begin
        hold_left[k]--;
        if (hold_left[k] <= 0) begin
          lvl[k] = !lvl[k];
          hold_left[k] = $urandom_range(1, 25);
        end
      end
      key_mode = lvl[0]; key_minute = lvl[1]; key_hour = lvl[2];
      step(1);
    end
    key_mode = 1'b1; key_minute = 1'b1; key_hour = 1'b1;
    step(20);

    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

endmodule
